adder_share_ctrl: RTL
=====================

Name: adder_share_ctrl

Overview:
- Sequencer/arbiter that shares the single 8-bit ripple/prefix adder (external combinational instance, A/B/Cin → Sum) between two requesters in the multicycle RISC.
  - Requester 0: ALU add/sub.
  - Requester 1: PC/address calculation.
- Latches operands on grant and drives the adder, performing subtraction as A + ~B + 1.
- Holds the adder inputs for a programmable settle time, registers the sum, and returns it with a valid/ready handshake.

Parameters:
- WIDTH, 8, datapath width; must match adder width.
- EXEC_CYCLES, 1, clocks the adder inputs are held stable before sum capture; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 request; level.
- op0  in  1  requester 0 op; 0 = add, 1 = sub.
- a0  in  WIDTH  requester 0 operand A.
- b0  in  WIDTH  requester 0 operand B.
- req1, op1, a1, b1: same as above, for requester 1.
- gnt0  out  1  one-cycle pulse; requester 0 operands latched this cycle.
- gnt1  out  1  one-cycle pulse; requester 1 operands latched this cycle.
- add_a  out  WIDTH  to adder A.
- add_b  out  WIDTH  to adder B; already inverted for sub.
- add_cin  out  1  to adder Cin; equals op.
- add_sum  in  WIDTH  from adder Sum.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  registered sum.
- res_id  out  1  which requester owns res_data.
- res_flags  out  3  {ovf, neg, zero}; see Optional Feature.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs, including add_a/add_b/add_cin, are 0.
  - State = IDLE, settle counter = 0, last-winner pointer = 1, so requester 0 wins the first tie.
- Reset mid-operation: any in-flight result is discarded; no res_valid is produced for it.
- FSM states: IDLE, EXEC, RESP; encodings come from the package.
- IDLE:
  - If any req is high, the arbiter picks a winner and pulses its gnt for exactly 1 cycle.
  - On that same edge: latch op, a, and op ? ~b : b into the operand registers; record the winner id; set the pointer; go to EXEC.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not granted last wins (round robin).
- EXEC:
  - add_a/add_b/add_cin are driven from the operand registers and stay constant for the whole state.
  - The counter counts EXEC_CYCLES clocks.
  - On the last EXEC cycle's edge: add_sum → res_data; compute flags; go to RESP.
- RESP:
  - res_valid is high and res_data/res_id/res_flags are stable until the handshake.
  - Handshake: res_valid && res_ready on an edge → go to IDLE and drop res_valid.
  - Backpressure: res_ready low holds RESP indefinitely.
- Latency:
  - gnt → res_valid = EXEC_CYCLES + 1 clocks (2 at default).
  - Minimum request-to-request spacing = EXEC_CYCLES + 3 clocks.
- Requester protocol:
  - gnt consumes exactly one request. A req still high after its gnt is treated as a new request.
  - Operands may change in the cycle after gnt.
  - req high while busy waits; it is never dropped or granted out of IDLE.
- Arithmetic: modulo 2^WIDTH; carry-out is not reported.
- add_* outputs hold their last values in IDLE and RESP; they are only reloaded at a grant.

Optional Feature:
- Macro: ADDSHARE_FLAGS_EN.
- Defined: flags are registered together with res_data.
  - zero = (sum == 0).
  - neg = sum[MSB].
  - ovf = (add_a[MSB] == add_b[MSB]) && (sum[MSB] != add_a[MSB]), using the post-inversion B.
- Undefined: res_flags is tied to 0 and no flag logic is synthesised.

Decomposition:
- Package adder_share_pkg holds:
  - state encoding constants ST_IDLE, ST_EXEC, ST_RESP;
  - op constants OP_ADD = 0, OP_SUB = 1;
  - flag bit index constants FLG_ZERO, FLG_NEG, FLG_OVF.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], an enable, and the pointer register.
  - Output: one-hot grant.
  - Reused later for register-file port sharing.

Test Plan:
- Single add (default params): req0 = 1, op0 = 0, a0 = 0x01, b0 = 0xFC → gnt0 pulse; res_valid 2 clocks later; res_data = 0xFD, res_id = 0, flags = {0,1,0}.
- Sub with zero: req1 = 1, op1 = 1, a1 = 0x04, b1 = 0x04 → add_b = 0xFB, add_cin = 1 during EXEC; res_data = 0x00, zero = 1, res_id = 1.
- Overflow and negative sub:
  - add 0x7F + 0x01 → res_data = 0x80, ovf = 1, neg = 1.
  - sub 0xFF − 0xFE → res_data = 0x01, flags = 0.
- Tie and round robin: req0 = req1 = 1 continuously after reset, res_ready = 1 → grant order 0, 1, 0, 1; each grant exactly one pulse; spacing 4 clocks.
- Backpressure: res_ready = 0 for 5 cycles in RESP → res_valid and res_data stable; req0 held high gets no gnt until 1 cycle after the handshake.
- Reset mid-EXEC: assert rst_n = 0 asynchronously while busy → all outputs 0 immediately; after release, no res_valid appears until a new grant, and requester 0 wins a tie.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing sequencer: FSM state encoding,
// operation codes and result-flag bit positions.
package adder_share_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Requester operation codes
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit positions inside res_flags = {ovf, neg, zero}
  localparam int FLG_ZERO = 0;
  localparam int FLG_NEG  = 1;
  localparam int FLG_OVF  = 2;
  localparam int FLG_W    = 3;

  // Settle counter width; covers the count 0..EXEC_CYCLES for EXEC_CYCLES up to 4
  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer holds the id of the last winner;
// on a tie the other requester wins. Purely combinational so it can be
// reused wherever a pair of requesters shares one resource.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot grant: a lone requester always wins, a tie goes to the one not served last
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Sequencer that shares one external combinational adder between the ALU
// (requester 0) and the PC/address unit (requester 1). A grant latches the
// winner's operands (B pre-inverted for subtraction, Cin = op), the adder
// inputs are held while the sum settles, the sum is registered and returned
// through a valid/ready handshake.
// Optional build macro: ADDSHARE_FLAGS_EN enables the {ovf, neg, zero}
// result flags; without it res_flags is constant zero.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic [2:0]       res_flags,
  output logic             busy
);

  // The EXEC state lasts EXEC_CYCLES+1 clocks: the first clock lets the freshly
  // loaded operand registers propagate through the adder, then EXEC_CYCLES
  // settle clocks follow before the sum is captured.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 4) begin : g_bad_exec_cycles
    $error("adder_share_ctrl: EXEC_CYCLES must be in 1..4");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ptr;
  logic             arb_en;
  logic [1:0]       arb_gnt;
  logic             win_id;
  logic             sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             capture;

  // Subtraction is performed as A + ~B + 1, so B is inverted before it reaches the adder
  function automatic logic [WIDTH-1:0] prep_b(input logic op, input logic [WIDTH-1:0] b);
    return (op == OP_SUB) ? ~b : b;
  endfunction

  assign arb_en  = (state == ST_IDLE);
  assign win_id  = arb_gnt[1];
  assign capture = (state == ST_EXEC) && (cnt == CNT_LAST);

  rr_arb2 u_arb (
    .req (({req1, req0})),
    .en  (arb_en),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Operand mux: pick the arbitration winner's op and operands
  always_comb begin
    sel_op = win_id ? op1 : op0;
    sel_a  = win_id ? a1  : a0;
    sel_b  = prep_b(sel_op, win_id ? b1 : b0);
  end

  // Control FSM with registered grant, adder-drive and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ptr       <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      add_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_gnt != 2'b00) begin
            gnt0    <= arb_gnt[0];
            gnt1    <= arb_gnt[1];
            add_a   <= sel_a;
            add_b   <= sel_b;
            add_cin <= sel_op;
            res_id  <= win_id;
            ptr     <= win_id;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == CNT_LAST) begin
            res_data  <= add_sum;
            res_valid <= 1'b1;
            cnt       <= '0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ADDSHARE_FLAGS_EN
  logic [FLG_W-1:0] flags_q;

  // Overflow uses the post-inversion B so one rule covers both add and sub
  function automatic logic [FLG_W-1:0] calc_flags(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] s);
    logic [FLG_W-1:0] f;
    f           = '0;
    f[FLG_ZERO] = (s == '0);
    f[FLG_NEG]  = s[WIDTH-1];
    f[FLG_OVF]  = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return f;
  endfunction

  // Flags are captured on the same edge as res_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (capture) begin
      flags_q <= calc_flags(add_a, add_b, add_sum);
    end
  end

  assign res_flags = flags_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign res_flags      = '0;
`endif

endmodule
